// File: rtl/uart_pkg.sv
// uart_pkg: shared parity/baud constants and the transmitter FSM encoding.
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD = 1;
  localparam int PAR_EVEN = 2;
  localparam int BPS_50MHz_9600 = 5208;
  localparam int BPS_50MHz_115200 = 434;
  localparam int BPS_12MHz_9600 = 1250;
  localparam int BPS_12MHz_115200 = 104;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} tx_state_t;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous first-word-fall-through FIFO; pointers carry a wrap bit
// so that full and empty are distinguishable.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic do_push, do_pop;
  always_comb begin
    level = wr_q - rd_q;
    empty = wr_q == rd_q;
    full = level == (AW+1)'(DEPTH);
    do_push = push && !full;
    do_pop = pop && !empty;
    wr_d = wr_q + (AW+1)'(do_push);
    rd_d = rd_q + (AW+1)'(do_pop);
    dout = mem_q[rd_q[AW-1:0]];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter (data width, parity, stop bits) fed
// from an internal FIFO; frames go out back-to-back while words are queued.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = BPS_50MHz_115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = PAR_NONE,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx_pin
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS);

  if (CLK_DIV < 2 || CLK_DIV > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < PAR_NONE || PARITY > PAR_EVEN || STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("uart_tx_param: illegal parameter set");
  end

  tx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, fifo_dout;
  logic par_q, par_d, pin_q, pin_d, busy_q, busy_d, done_q, done_d;
  logic last, pop, empty, full;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(tx_valid), .pop(pop), .din(tx_data),
    .dout(fifo_dout), .full(full), .empty(empty), .level(fifo_level)
  );

  always_comb begin
    last = cnt_q == CW'(CLK_DIV - 1);
    cnt_d = (state_q == IDLE || last) ? '0 : cnt_q + 1'b1;
    state_d = state_q;
    idx_d = idx_q;
    sh_d = sh_q;
    par_d = par_q;
    pop = 1'b0;
    done_d = 1'b0;
    case (state_q)
      IDLE: pop = !empty;
      START: if (last) state_d = DATA;
      DATA: if (last) begin
        sh_d = sh_q >> 1;
        idx_d = idx_q == BW'(DATA_BITS - 1) ? '0 : idx_q + 1'b1;
        if (idx_q == BW'(DATA_BITS - 1)) state_d = PARITY != PAR_NONE ? PAR : STOP;
      end
      PAR: if (last) state_d = STOP;
      STOP: if (last) begin
        idx_d = idx_q == BW'(STOP_BITS - 1) ? '0 : idx_q + 1'b1;
        if (idx_q == BW'(STOP_BITS - 1)) begin
          done_d = 1'b1;
          pop = !empty;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      state_d = START;
      sh_d = fifo_dout;
      par_d = ^fifo_dout ^ (PARITY == PAR_ODD);
    end
    // Line outputs are registered from the current state, so the pin trails the FSM by one clock.
    pin_d = state_q == START ? 1'b0 : state_q == DATA ? sh_q[0] : state_q == PAR ? par_q : 1'b1;
    busy_d = state_q != IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      sh_q <= '0;
      par_q <= 1'b0;
      pin_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      par_q <= par_d;
      pin_q <= pin_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign tx_ready = !full;
  assign tx_busy = busy_q;
  assign tx_done = done_q;
  assign tx_pin = pin_q;
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: several transmitter configurations driven side by side; a line
// decoder per instance checks every frame against a queue of accepted words.
module tb_uart_tx_param;
  localparam int NI = 6;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  bit fin [NI];

  function automatic void chk(input int g, input string name, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL u%0d %s: got %0d expected %0d", g, name, got, exp);
    end
  endfunction

  // {CLK_DIV, DATA_BITS, PARITY, STOP_BITS, FIFO_DEPTH}
  function automatic logic [47:0] cfg(input int g);
    case (g)
      0: cfg = {16'd434, 8'd8, 8'd0, 8'd1, 8'd4};
      1: cfg = {16'd5, 8'd8, 8'd2, 8'd1, 8'd4};
      2: cfg = {16'd4, 8'd8, 8'd1, 8'd1, 8'd2};
      3: cfg = {16'd3, 8'd7, 8'd0, 8'd2, 8'd8};
      4: cfg = {16'd2, 8'd9, 8'd1, 8'd2, 8'd4};
      default: cfg = {16'd2, 8'd5, 8'd2, 8'd1, 8'd2};
    endcase
  endfunction

  function automatic bit all_fin();
    for (int i = 0; i < NI; i++) if (!fin[i]) return 1'b0;
    return 1'b1;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : u
    localparam logic [47:0] C = cfg(g);
    localparam int CD = int'(C[47:32]);
    localparam int DB = int'(C[31:24]);
    localparam int PA = int'(C[23:16]);
    localparam int SB = int'(C[15:8]);
    localparam int FD = int'(C[7:0]);
    localparam int L = CD * (1 + DB + (PA != 0 ? 1 : 0) + SB);
    logic rst = 1'b1;
    logic tx_valid = 1'b0;
    logic [DB-1:0] tx_data = '0;
    logic tx_ready, tx_busy, tx_done, tx_pin;
    logic [$clog2(FD):0] fifo_level;
    logic [DB-1:0] exp_q [$];
    logic [DB-1:0] cur = '0;
    int c = 0;
    bit inf = 1'b0;

    uart_tx_param #(.CLK_DIV(CD), .DATA_BITS(DB), .PARITY(PA), .STOP_BITS(SB), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .tx_busy(tx_busy), .tx_done(tx_done), .fifo_level(fifo_level), .tx_pin(tx_pin)
    );

    // Bit k of the frame for word d: start, data LSB first, optional parity, stop bits.
    function automatic bit exp_bit(input logic [DB-1:0] d, input int k);
      if (k == 0) return 1'b0;
      if (k <= DB) return d[k-1];
      if (PA != 0 && k == DB + 1) return PA == 1 ? ~^d : ^d;
      return 1'b1;
    endfunction

    always @(negedge clk) begin
      if (rst) begin
        inf = 1'b0;
        chk(g, "rst_pin", tx_pin, 1);
        chk(g, "rst_busy", tx_busy, 0);
        chk(g, "rst_done", tx_done, 0);
        chk(g, "rst_level", fifo_level, 0);
        chk(g, "rst_ready", tx_ready, 1);
      end else begin
        if (!inf && !tx_pin) begin
          chk(g, "frame_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) cur = exp_q.pop_front();
          inf = 1'b1;
          c = 0;
        end
        chk(g, "busy", tx_busy, inf);
        chk(g, "done", tx_done, inf && c == L - 1);
        if (inf) begin
          if (c % CD == CD / 2) chk(g, $sformatf("bit%0d", c / CD), tx_pin, exp_bit(cur, c / CD));
          c++;
          if (c == L) inf = 1'b0;
        end
      end
    end

    task automatic send(input logic [DB-1:0] d);
      int t = 0;
      tx_valid = 1'b1;
      tx_data = d;
      while (!tx_ready && t < 20 * L) begin
        @(negedge clk);
        t++;
      end
      chk(g, "send_ready", tx_ready, 1);
      if (tx_ready) exp_q.push_back(d);
      @(negedge clk);
      tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
      int t = 0;
      while ((exp_q.size() != 0 || inf || tx_busy) && t < 100 * L) begin
        @(negedge clk);
        t++;
      end
      chk(g, "idle_reached", t < 100 * L, 1);
    endtask

    task automatic wait_done(output int n);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!tx_done && n < 3 * L);
      chk(g, "done_seen", tx_done, 1);
    endtask

    task automatic do_reset(input int n);
      #2 rst = 1'b1;
      #1;
      chk(g, "async_pin", tx_pin, 1);
      chk(g, "async_level", fifo_level, 0);
      chk(g, "async_done", tx_done, 0);
      repeat (n) @(negedge clk);
      exp_q.delete();
      rst = 1'b0;
    endtask

    if (g == 0) begin : d
      initial begin
        int n, acc;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk(g, "idle_ready", tx_ready, 1);
        exp_q.push_back(DB'('h55));
        tx_valid = 1'b1;
        tx_data = DB'('h55);
        @(negedge clk);
        tx_valid = 1'b0;
        chk(g, "lat1_level", fifo_level, 1);
        chk(g, "lat1_pin", tx_pin, 1);
        @(negedge clk);
        chk(g, "lat2_level", fifo_level, 0);
        chk(g, "lat2_pin", tx_pin, 1);
        @(negedge clk);
        chk(g, "lat3_pin", tx_pin, 0);
        wait_idle();
        send(DB'('h55));
        send(DB'('hAA));
        send(DB'('h3B));
        chk(g, "b2b_level", fifo_level, 2);
        wait_done(n);
        chk(g, "b2b_level_d1", fifo_level, 1);
        wait_done(n);
        chk(g, "b2b_gap1", n, L);
        chk(g, "b2b_level_d2", fifo_level, 0);
        wait_done(n);
        chk(g, "b2b_gap2", n, L);
        wait_idle();
        acc = 0;
        for (int i = 1; i <= 7; i++) begin
          tx_valid = 1'b1;
          tx_data = DB'(i);
          if (tx_ready) begin
            exp_q.push_back(DB'(i));
            acc++;
          end
          @(negedge clk);
        end
        tx_valid = 1'b0;
        chk(g, "full_accepted", acc, FD + 1);
        chk(g, "full_level", fifo_level, FD);
        n = 0;
        while (!tx_done && n < 2 * L) begin
          chk(g, "full_ready_low", tx_ready, 0);
          @(negedge clk);
          n++;
        end
        chk(g, "full_done", tx_done, 1);
        chk(g, "ready_after_done", tx_ready, 1);
        wait_idle();
        send(DB'('hA5));
        send(DB'('h0F));
        send(DB'('hF0));
        repeat (CD + 1000) @(negedge clk);
        do_reset(3);
        @(negedge clk);
        chk(g, "post_rst_pin", tx_pin, 1);
        chk(g, "post_rst_level", fifo_level, 0);
        send(DB'('hC3));
        wait_idle();
        fin[g] = 1'b1;
      end
    end else begin : r
      initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(DB'(g == 3 ? 'h41 : 'h3B));
        for (int i = 0; i < 60; i++) begin
          if (g == 1 && i == 30) begin
            repeat ($urandom_range(L, 1)) @(negedge clk);
            do_reset(2);
          end
          repeat ($urandom_range(3, 0) == 0 ? $urandom_range(2 * L, 1) : 0) @(negedge clk);
          send(DB'($urandom));
        end
        wait_idle();
        fin[g] = 1'b1;
      end
    end
  end

  initial begin
    int t = 0;
    while (t < 95000 && !all_fin()) begin
      @(negedge clk);
      t++;
    end
    chk(NI, "all_finished", all_fin(), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1 tx_module family. It adds configurable data width, parity and stop bits, plus an internal FIFO with a valid/ready write handshake. Frames leave back-to-back with no idle gap while data is queued, and a per-frame done pulse is kept. It sits between any byte-producing control FSM and the board TX pin.

Parameters:
CLK_DIV, 434, clocks per bit (BPS_50MHz_115200); legal range 2..65535
DATA_BITS, 8, data bits per frame, legal 5..9, sent LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even; 3 is illegal and is caught by an elaboration check
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, queue depth; power of 2, >= 2

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
tx_valid  in  1  write request
tx_data  in  DATA_BITS  word to send; sampled when tx_valid && tx_ready
tx_ready  out  1  FIFO not full
tx_busy  out  1  high while a frame is on the line (state != IDLE)
tx_done  out  1  one-clk pulse at the end of each frame's last stop bit
fifo_level  out  $clog2(FIFO_DEPTH)+1  words queued, excluding the frame in flight
tx_pin  out  1  serial line, idle high, registered

Behaviour:
- Reset values: tx_pin = 1, tx_ready = 1, tx_busy = 0, tx_done = 0, fifo_level = 0, FIFO pointers = 0, FSM = IDLE, baud counter = 0.
- Reset asserted mid-frame:
  - tx_pin returns high asynchronously.
  - The frame is abandoned with no tx_done.
  - Queued data is discarded.
- Write handshake:
  - A word is accepted on a rising edge where tx_valid && tx_ready.
  - tx_ready = !full, purely from occupancy.
  - A push while full is dropped, even if a pop happens on the same edge.
  - A simultaneous push and pop on a non-full FIFO leaves fifo_level unchanged.
- Baud counter runs 0..CLK_DIV-1. A bit period ends on the edge where the counter equals CLK_DIV-1, and the counter then reloads 0.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: tx_pin = 1. If the FIFO is non-empty, pop into the shift register, compute parity, go to START.
  - START: tx_pin = 0 for CLK_DIV clocks, then go to DATA.
  - DATA: shift out DATA_BITS bits LSB first, one per bit period; a bit index counts 0..DATA_BITS-1. Then go to PAR if PARITY != 0, else STOP.
  - PAR: one bit period.
    - Even: parity bit = XOR of the data bits.
    - Odd: parity bit = the inverted XOR.
  - STOP: tx_pin = 1 for STOP_BITS*CLK_DIV clocks.
    - At the final edge, pulse tx_done for one clock.
    - If the FIFO is non-empty on that edge, pop and go directly to START (zero idle clocks).
    - Otherwise go to IDLE.
- Latency: a word accepted at edge N into an empty FIFO while IDLE is popped at edge N+1. tx_pin falls after edge N+2.
- Frame length in clocks: CLK_DIV*(1 + DATA_BITS + (PARITY != 0) + STOP_BITS).
- Parity and data are captured at pop, so changes to tx_data after acceptance have no effect on the frame in flight.
- fifo_level saturates at FIFO_DEPTH. Pointers use an extra wrap bit to separate full from empty.

Decomposition:
- Package uart_pkg holds:
  - parity constants PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2;
  - BPS constants BPS_50MHz_9600 = 5208, BPS_50MHz_115200 = 434, BPS_12MHz_9600 = 1250, BPS_12MHz_115200 = 104;
  - the FSM state encoding.
- One sub-module: uart_sync_fifo (WIDTH, DEPTH), a synchronous FIFO with push/pop/full/empty/level and the same clk/rst.
- Baud counter and FSM stay in uart_tx_param.

Test Plan:
1. Defaults (CLK_DIV = 434, 8N1). Push 8'h55 once while idle -> tx_pin falls 2 clks after acceptance, then shows 0,1,0,1,0,1,0,1,0,1 at 434 clks each. tx_done pulses exactly 4340 clks after the start bit began; tx_busy drops the next clk.
2. Queue 8'h55, 8'hAA, 8'h3B back-to-back -> three tx_done pulses spaced exactly 4340 clks. tx_pin never idles high between frames beyond the stop bit; fifo_level steps 1→0 as frames start.
3. PARITY = 2 with 8'h3B (five ones) -> parity bit 1, frame 4774 clks. PARITY = 1 with the same data -> parity bit 0.
4. DATA_BITS = 7, STOP_BITS = 2, PARITY = 0, send 7'h41 -> bits 0,1,0,0,0,0,0,1,1,1; frame 4340 clks.
5. FIFO_DEPTH = 4, hold tx_valid with data 1..7 every clk from idle -> words 1..5 accepted (one popped immediately). tx_ready low from the 6th clk until the first tx_done; words 1..5 transmitted in order.
6. Assert rst 1000 clks into the data phase -> tx_pin high within the same cycle, no tx_done, fifo_level = 0. A fresh push after release gives a clean frame.
